ft_bus_arbiter: RTL
===================

FT_BUS_ARBITER -- requirements
Module: ft_bus_arbiter

Interface
REQ-001 SHALL have parameter BURST_MAX, default 16: max words per direction grant before re-arbitration (legal 2..255).
REQ-002 SHALL have port CLK  in  1  FT chip clock, 100 MHz, all logic on rising edge.
REQ-003 SHALL have port RST_N  in  1  asynchronous, active-low reset.
REQ-004 SHALL have ports TXE_N  in  1  chip can accept a write (low); RXF_N  in  1  chip has read data (low).
REQ-005 SHALL have ports WR_N, RD_N, OE_N  out  1 each  chip strobes, active low, registered.
REQ-006 SHALL have ports DATA_OUT  out  32, BE_OUT  out  4, DATA_OE  out  1  (high = block drives DATA/BE pads).
REQ-007 SHALL have ports DATA_IN  in  32, BE_IN  in  4  pad input values.
REQ-008 SHALL have ports tx_valid  in  1, tx_data  in  32, tx_ready  out  1  host-bound word stream.
REQ-009 SHALL have ports rx_valid  out  1, rx_data  out  32, rx_be  out  4  chip-read word stream, no backpressure.
REQ-010 SHALL have port rx_afull  in  1  downstream can absorb at most 2 more words.

Function
REQ-011 SHALL implement states IDLE, TX_BURST, RX_OE, RX_BURST, RX_END.
REQ-012 IDLE: tx pending = tx_valid & !TXE_N; rx pending = !RXF_N & !rx_afull.
REQ-013 IDLE, one pending -> grant it; both pending -> grant opposite of last_dir; last_dir updated on grant; last_dir resets to RX (first tie goes TX).
REQ-014 TX grant: IDLE -> TX_BURST, DATA_OE=1 from that cycle, burst count cleared.
REQ-015 TX_BURST: tx_ready = !TXE_N & (count < BURST_MAX); handshake = tx_valid & tx_ready.
REQ-016 On handshake, next cycle: WR_N=0, DATA_OUT=tx_data, BE_OUT=4'b1111, count+1; without handshake next cycle WR_N=1.
REQ-017 TX_BURST exits to IDLE the cycle after any non-handshake cycle or after count reaches BURST_MAX; WR_N=1 and DATA_OE=0 on entry to IDLE.
REQ-018 RX grant: IDLE -> RX_OE: DATA_OE=0, OE_N=0, RD_N=1 for exactly one cycle (bus turnaround).
REQ-019 RX_OE -> RX_BURST: RD_N=0, OE_N=0.
REQ-020 RX_BURST: word accepted on each edge with RD_N=0 & RXF_N=0; next cycle rx_valid=1, rx_data=DATA_IN, rx_be=BE_IN captured at that edge, count+1.
REQ-021 RX_BURST ends when RXF_N=1, rx_afull=1, or count reaches BURST_MAX: RD_N=1 next cycle, -> RX_END.
REQ-022 RX_END: OE_N=1, RD_N=1, DATA_OE=0 for one cycle, then IDLE; DATA_OE SHALL never be 1 while OE_N=0 or in the cycle after OE_N rises.
REQ-023 rx_valid SHALL be a 1-cycle pulse per accepted word; edges with RXF_N=1 SHALL NOT produce rx_valid.
REQ-024 WR_N=0 and RD_N=0 SHALL never coincide; tx_ready SHALL be 0 outside TX_BURST.
REQ-025 count width = clog2(BURST_MAX+1); no wrap: saturates at BURST_MAX, cleared on every grant.
REQ-026 TXE_N rising mid-burst: word handshaken that cycle is still written (WR_N=0 next cycle); tx_ready falls same cycle.

Reset
REQ-027 RST_N=0 asynchronously forces IDLE, WR_N=RD_N=OE_N=1, DATA_OE=0, tx_ready=0, rx_valid=0, DATA_OUT=0, BE_OUT=0, rx_data=0, rx_be=0, count=0, last_dir=RX.
REQ-028 Release SHALL be synchronised internally (2-flop) so first state change occurs no earlier than second rising edge after RST_N rises.
REQ-029 Reset mid-burst SHALL abort immediately with no further strobe; any in-flight word is dropped.

Verification
REQ-030 Reset: assert RST_N=0 mid-cycle with strobes active -> all outputs at REQ-027 values before next edge.
REQ-031 TX 3 words 0xA1,0xA2,0xA3 with TXE_N=0, RXF_N=1 -> WR_N low 3 consecutive cycles, DATA_OUT matches order, BE_OUT=1111, then IDLE.
REQ-032 tx_valid held, TXE_N=0, RXF_N=0, BURST_MAX=4 -> exactly 4 writes, IDLE, one RX_OE turnaround cycle, then RX_BURST.
REQ-033 RX with RXF_N=0 for 5 edges then 1 -> exactly 5 rx_valid pulses, data in order, RD_N=1 next cycle, one RX_END cycle.
REQ-034 Both pending continuously -> grants alternate TX,RX,TX,RX; DATA_OE=0 whenever OE_N=0.
REQ-035 rx_afull=1 during RX_BURST -> RD_N high next cycle, at most 1 further rx_valid; RST_N=0 during TX_BURST -> WR_N=1 immediately.

Source files
------------

// File: rtl/ft_bus_arbiter_if.sv
// Bundle of FT chip pad signals and the two word streams served by ft_bus_arbiter.
// tx stream: a word moves on every rising edge where tx_valid & tx_ready; rx stream has no ready, each rx_valid pulse is one word.
interface ft_bus_arbiter_if;
   logic        TXE_N;
   logic        RXF_N;
   logic        WR_N;
   logic        RD_N;
   logic        OE_N;
   logic [31:0] DATA_OUT;
   logic [3:0]  BE_OUT;
   logic        DATA_OE;
   logic [31:0] DATA_IN;
   logic [3:0]  BE_IN;
   logic        tx_valid;
   logic [31:0] tx_data;
   logic        tx_ready;
   logic        rx_valid;
   logic [31:0] rx_data;
   logic [3:0]  rx_be;
   logic        rx_afull;

   modport master (
      input  TXE_N, RXF_N, DATA_IN, BE_IN, tx_valid, tx_data, rx_afull,
      output WR_N, RD_N, OE_N, DATA_OUT, BE_OUT, DATA_OE, tx_ready, rx_valid, rx_data, rx_be
   );

   modport slave (
      output TXE_N, RXF_N, DATA_IN, BE_IN, tx_valid, tx_data, rx_afull,
      input  WR_N, RD_N, OE_N, DATA_OUT, BE_OUT, DATA_OE, tx_ready, rx_valid, rx_data, rx_be
   );
endinterface

// File: rtl/ft_bus_arbiter.sv
// Half-duplex FT bus arbiter: alternates bounded write bursts and read bursts on a shared
// data bus, with a one-cycle OE turnaround before reads and a one-cycle idle after them.
module ft_bus_arbiter #(
   parameter int unsigned BURST_MAX = 16
) (
   input  logic              CLK,
   input  logic              RST_N,
   ft_bus_arbiter_if.master  bus,
   output logic [2:0]        o_state
);
   localparam int unsigned CW = $clog2(BURST_MAX + 1);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      TX_BURST = 3'd1,
      RX_OE    = 3'd2,
      RX_BURST = 3'd3,
      RX_END   = 3'd4
   } state_t;

   logic [1:0]    r_rst_sync;
   logic          w_rst_n;
   state_t        r_state;
   state_t        w_next;
   logic [CW-1:0] r_count;
   logic          r_last_tx;
   logic          r_wr_n, r_rd_n, r_oe_n, r_data_oe, r_rx_valid;
   logic [31:0]   r_data_out, r_rx_data;
   logic [3:0]    r_be_out, r_rx_be;

   logic          w_tx_pend, w_rx_pend, w_grant_tx, w_grant_rx;
   logic          w_tx_ready, w_tx_hs, w_rx_acc, w_rx_stop;
   logic [CW-1:0] w_cnt_inc;
   logic          w_wr_n_d, w_rd_n_d, w_oe_n_d, w_data_oe_d, w_rx_valid_d, w_last_tx_d;
   logic [31:0]   w_data_out_d, w_rx_data_d;
   logic [3:0]    w_be_out_d, w_rx_be_d;
   logic [CW-1:0] w_count_d;

   // Assertion is immediate; release only reaches the logic after two edges.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) r_rst_sync <= 2'b00;
      else        r_rst_sync <= {r_rst_sync[0], 1'b1};
   end
   assign w_rst_n = r_rst_sync[1];

   assign w_tx_pend  = bus.tx_valid & ~bus.TXE_N;
   assign w_rx_pend  = ~bus.RXF_N & ~bus.rx_afull;
   assign w_grant_tx = w_tx_pend & (~w_rx_pend | ~r_last_tx);
   assign w_grant_rx = w_rx_pend & (~w_tx_pend | r_last_tx);
   assign w_tx_hs    = bus.tx_valid & w_tx_ready;
   assign w_rx_acc   = (r_state == RX_BURST) & ~r_rd_n & ~bus.RXF_N;
   assign w_rx_stop  = bus.RXF_N | bus.rx_afull | (w_rx_acc & (r_count == CW'(BURST_MAX - 1)));
   assign w_cnt_inc  = (r_count == CW'(BURST_MAX)) ? r_count : r_count + 1'b1;

   always_ff @(posedge CLK or negedge w_rst_n) begin
      if (!w_rst_n) r_state <= IDLE;
      else          r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:     if (w_grant_tx) w_next = TX_BURST;
                   else if (w_grant_rx) w_next = RX_OE;
         TX_BURST: if (!w_tx_hs) w_next = IDLE;
         RX_OE:    w_next = RX_BURST;
         RX_BURST: if (w_rx_stop) w_next = RX_END;
         RX_END:   w_next = IDLE;
         default:  w_next = IDLE;
      endcase
   end

   always_comb begin
      w_wr_n_d     = 1'b1;
      w_rd_n_d     = 1'b1;
      w_oe_n_d     = 1'b1;
      w_data_oe_d  = 1'b0;
      w_rx_valid_d = 1'b0;
      w_tx_ready   = 1'b0;
      w_data_out_d = r_data_out;
      w_be_out_d   = r_be_out;
      w_rx_data_d  = r_rx_data;
      w_rx_be_d    = r_rx_be;
      w_count_d    = r_count;
      w_last_tx_d  = r_last_tx;
      case (r_state)
         IDLE: begin
            if (w_grant_tx) begin
               w_data_oe_d = 1'b1;
               w_count_d   = '0;
               w_last_tx_d = 1'b1;
            end else if (w_grant_rx) begin
               w_oe_n_d    = 1'b0;
               w_count_d   = '0;
               w_last_tx_d = 1'b0;
            end
         end
         TX_BURST: begin
            w_tx_ready = ~bus.TXE_N & (r_count < CW'(BURST_MAX));
            // Pads stay driven through the final strobe; released on the way back to IDLE.
            if (w_tx_hs) begin
               w_wr_n_d     = 1'b0;
               w_data_oe_d  = 1'b1;
               w_data_out_d = bus.tx_data;
               w_be_out_d   = 4'b1111;
               w_count_d    = w_cnt_inc;
            end
         end
         RX_OE: begin
            w_rd_n_d = 1'b0;
            w_oe_n_d = 1'b0;
         end
         RX_BURST: begin
            if (w_rx_acc) begin
               w_rx_valid_d = 1'b1;
               w_rx_data_d  = bus.DATA_IN;
               w_rx_be_d    = bus.BE_IN;
               w_count_d    = w_cnt_inc;
            end
            if (!w_rx_stop) begin
               w_rd_n_d = 1'b0;
               w_oe_n_d = 1'b0;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge CLK or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_wr_n     <= 1'b1;
         r_rd_n     <= 1'b1;
         r_oe_n     <= 1'b1;
         r_data_oe  <= 1'b0;
         r_rx_valid <= 1'b0;
         r_data_out <= '0;
         r_be_out   <= '0;
         r_rx_data  <= '0;
         r_rx_be    <= '0;
         r_count    <= '0;
         r_last_tx  <= 1'b0;
      end else begin
         r_wr_n     <= w_wr_n_d;
         r_rd_n     <= w_rd_n_d;
         r_oe_n     <= w_oe_n_d;
         r_data_oe  <= w_data_oe_d;
         r_rx_valid <= w_rx_valid_d;
         r_data_out <= w_data_out_d;
         r_be_out   <= w_be_out_d;
         r_rx_data  <= w_rx_data_d;
         r_rx_be    <= w_rx_be_d;
         r_count    <= w_count_d;
         r_last_tx  <= w_last_tx_d;
      end
   end

   assign bus.WR_N     = r_wr_n;
   assign bus.RD_N     = r_rd_n;
   assign bus.OE_N     = r_oe_n;
   assign bus.DATA_OE  = r_data_oe;
   assign bus.DATA_OUT = r_data_out;
   assign bus.BE_OUT   = r_be_out;
   assign bus.tx_ready = w_tx_ready;
   assign bus.rx_valid = r_rx_valid;
   assign bus.rx_data  = r_rx_data;
   assign bus.rx_be    = r_rx_be;
   assign o_state      = r_state;
endmodule
